// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: size encodings, FSM states
// and the big-endian byte-enable decoder.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_RESP
  } state_t;

  // Enable bit 3 is bits [31:24] (byte offset 0). Misaligned or reserved
  // sizes yield no enables, which the top also uses as its store-error test.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] offset);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      SZ_BYTE: be = 4'b1000 >> offset;
      SZ_HALF: if (!offset[0]) be = offset[1] ? 4'b0011 : 4'b1100;
      SZ_WORD: if (offset == 2'b00) be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM, 32-bit words with four byte-write enables and a
// registered read port that only updates on read cycles.
module dmem_array #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rd_en,
  input  logic [3:0]           we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);

  localparam int DEPTH = 1 << ADDR_BITS;

  // One byte-wide bank per lane keeps each lane's write enable independent.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] q_reg;

      always_ff @(posedge clk) begin
        if (we[gi]) mem[addr] <= wdata[8*gi +: 8];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_reg <= 8'h00;
        else if (rd_en) q_reg <= mem[addr];
      end

      assign rdata[8*gi +: 8] = q_reg;
    end
  endgenerate

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: captures one request, inserts wait states,
// performs the aligned access and pulses Mem_Ready with an optional error.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MemRead_2DM,
  input  logic        MemWrite_2DM,
  input  logic [1:0]  MemSize_2DM,
  input  logic [31:0] data_address_2DM,
  input  logic [31:0] data_write_2DM,
  output logic [31:0] data_read_fDM,
  output logic        Mem_Ready,
  output logic        Mem_Error
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t               state_reg, state_next;
  logic [3:0]           cnt_reg, cnt_next;
  logic [ADDR_BITS+1:0] addr_reg;
  logic [31:0]          wdata_reg;
  logic [1:0]           size_reg;
  logic                 write_reg;
  logic                 both_reg;
  logic                 err_reg;
  logic                 req;
  logic                 accept;
  logic [3:0]           be;
  logic [3:0]           we;
  logic                 rd_en;
  logic [31:0]          lane_data;
  logic                 unused_addr;

  assign req         = MemRead_2DM | MemWrite_2DM;
  // The edge closing RESP also accepts, giving one request per WAIT_CYCLES+2.
  assign accept      = req && (state_reg == ST_IDLE || state_reg == ST_RESP);
  assign unused_addr = ^data_address_2DM[31:ADDR_BITS+2];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE, ST_RESP: begin
        state_next = ST_IDLE;
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            state_next = ST_ACCESS;
          end else begin
            state_next = ST_WAIT;
            cnt_next   = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_reg == 4'd0) state_next = ST_ACCESS;
        else cnt_next = cnt_reg - 4'd1;
      end
      ST_ACCESS: state_next = ST_RESP;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      addr_reg  <= '0;
      wdata_reg <= 32'h0;
      size_reg  <= SZ_BYTE;
      write_reg <= 1'b0;
      both_reg  <= 1'b0;
    end else if (accept) begin
      addr_reg  <= data_address_2DM[ADDR_BITS+1:0];
      wdata_reg <= data_write_2DM;
      size_reg  <= MemSize_2DM;
      write_reg <= MemWrite_2DM;
      both_reg  <= MemRead_2DM & MemWrite_2DM;
    end
  end

  assign be    = byte_en(size_reg, addr_reg[1:0]);
  assign we    = (state_reg == ST_ACCESS && write_reg) ? be : 4'b0000;
  assign rd_en = (state_reg == ST_ACCESS) && !write_reg;

  // Right-justified store data replicated so every candidate lane sees it.
  always_comb begin
    lane_data = wdata_reg;
    case (size_reg)
      SZ_BYTE: lane_data = {4{wdata_reg[7:0]}};
      SZ_HALF: lane_data = {2{wdata_reg[15:0]}};
      default: lane_data = wdata_reg;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      err_reg <= 1'b0;
    end else if (state_reg == ST_ACCESS) begin
      err_reg <= (write_reg && be == 4'b0000) || both_reg;
    end else if (state_reg == ST_RESP) begin
      err_reg <= 1'b0;
    end
  end

  dmem_array #(
    .ADDR_BITS(ADDR_BITS)
  ) u_array (
    .clk   (CLK),
    .rst_n (RESET),
    .rd_en (rd_en),
    .we    (we),
    .addr  (addr_reg[ADDR_BITS+1:2]),
    .wdata (lane_data),
    .rdata (data_read_fDM)
  );

  assign Mem_Ready = (state_reg == ST_RESP);
  assign Mem_Error = err_reg;

endmodule
